// File: rtl/s2p_frame_arbiter.sv
// Round-robin arbiter that shares one serial-to-parallel converter
// among NUM_REQ serial sources and returns each word with its source id.
module s2p_frame_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int FRAME_BITS = 8,
   parameter int TIMEOUT    = 16,
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    ser_d,
   output logic [NUM_REQ-1:0]    gnt,
   output logic                  s2p_start,
   output logic                  s2p_d,
   input  logic                  s2p_end,
   input  logic [FRAME_BITS-1:0] s2p_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [FRAME_BITS-1:0] out_data,
   output logic [ID_W-1:0]       out_id,
   output logic                  busy,
   output logic                  err_timeout
);

   localparam int BIT_W = $clog2(FRAME_BITS + 1);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_START,
      S_SHIFT,
      S_WAIT,
      S_OUT
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [ID_W-1:0]  grant_id;
   logic [ID_W-1:0]  last_id;
   logic [ID_W-1:0]  pick_id;
   logic [ID_W-1:0]  scan_id;
   logic             pick_vld;
   logic [BIT_W-1:0] bit_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             bit_last;
   logic             tmo_last;

   assign bit_last = (bit_cnt == BIT_W'(FRAME_BITS - 1));
   assign tmo_last = (tmo_cnt == TMO_W'(TIMEOUT - 1));

   // Scan from the farthest offset down so the nearest one after last_id wins.
   always_comb begin
      pick_id  = '0;
      pick_vld = 1'b0;
      scan_id  = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         scan_id = ID_W'((int'(last_id) + i) % NUM_REQ);
         if (req[scan_id]) begin
            pick_id  = scan_id;
            pick_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (pick_vld) state_nxt = S_GRANT;
         S_GRANT: state_nxt = S_START;
         S_START: state_nxt = S_SHIFT;
         S_SHIFT: if (bit_last) state_nxt = S_WAIT;
         S_WAIT: begin
            if (s2p_end)       state_nxt = S_OUT;
            else if (tmo_last) state_nxt = S_IDLE;
         end
         S_OUT:   if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy      = (state != S_IDLE);
   assign s2p_start = (state == S_START);
   assign s2p_d     = ((state == S_START) || (state == S_SHIFT))
                      ? ser_d[grant_id] : 1'b0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt         <= '0;
         grant_id    <= '0;
         last_id     <= ID_W'(NUM_REQ - 1);
         bit_cnt     <= '0;
         tmo_cnt     <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_id      <= '0;
         err_timeout <= 1'b0;
      end else begin
         err_timeout <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  grant_id <= pick_id;
                  gnt      <= NUM_REQ'(1) << pick_id;
               end
            end
            S_GRANT: bit_cnt <= '0;
            S_START: bit_cnt <= BIT_W'(1);
            S_SHIFT: begin
               bit_cnt <= bit_cnt + BIT_W'(1);
               if (bit_last) tmo_cnt <= '0;
            end
            S_WAIT: begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
               // End-of-conversion takes priority over a same-cycle timeout.
               if (s2p_end) begin
                  out_data  <= s2p_data;
                  out_id    <= grant_id;
                  out_valid <= 1'b1;
               end else if (tmo_last) begin
                  err_timeout <= 1'b1;
                  gnt         <= '0;
                  last_id     <= grant_id;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  gnt       <= '0;
                  last_id   <= grant_id;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_s2p_frame_arbiter.sv
// Directed bench for s2p_frame_arbiter: grant order, bit muxing,
// backpressure, timeout, end/timeout race and mid-frame reset.
module tb_s2p_frame_arbiter;

   localparam int TMO    = 16;
   localparam int M_NORM = 0;
   localparam int M_TMO  = 1;
   localparam int M_RACE = 2;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic [3:0] ser_d;
   logic [3:0] gnt;
   logic       s2p_start;
   logic       s2p_d;
   logic       s2p_end;
   logic [7:0] s2p_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] out_id;
   logic       busy;
   logic       err_timeout;

   int   checks = 0;
   int   errors = 0;
   logic exp_err = 1'b0;
   logic [7:0] words [4] = '{8'h3C, 8'h96, 8'hA5, 8'h5A};

   s2p_frame_arbiter #(
      .NUM_REQ(4),
      .FRAME_BITS(8),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .ser_d(ser_d),
      .gnt(gnt),
      .s2p_start(s2p_start),
      .s2p_d(s2p_d),
      .s2p_end(s2p_end),
      .s2p_data(s2p_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_id(out_id),
      .busy(busy),
      .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_start"}, s2p_start, 0);
      chk({tag, "_d"}, s2p_d, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_id"}, out_id, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err_timeout, 0);
   endtask

   task automatic frame(input logic [3:0] req_v, input bit drop,
                        input int src, input int mode,
                        input int hold, input bit spur);
      logic [7:0] w;
      logic [3:0] g;
      int         nw;
      bit         fin;
      w = words[src];
      g = 4'b0001 << src;
      @(negedge clk);
      req = req_v;
      ser_d = '0;
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_gnt", gnt, 0);
      chk("idle_valid", out_valid, 0);
      chk("idle_err", err_timeout, exp_err);
      exp_err = 1'b0;
      @(negedge clk);
      if (drop) req = '0;
      #1;
      chk("gnt", gnt, g);
      chk("grant_start", s2p_start, 0);
      chk("grant_d", s2p_d, 0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) ser_d[i] = words[i][k];
         s2p_end  = spur && (k == 4);
         s2p_data = (spur && (k == 4)) ? 8'hFF : 8'h00;
         #1;
         chk("start", s2p_start, (k == 0));
         chk("bit", s2p_d, w[k]);
         chk("gnt_hold", gnt, g);
         chk("onehot", $onehot0(gnt), 1);
         chk("shift_valid", out_valid, 0);
      end
      nw = (mode == M_NORM) ? 1 : TMO;
      for (int c = 0; c < nw; c++) begin
         @(negedge clk);
         ser_d = '0;
         fin = (mode != M_TMO) && (c == nw - 1);
         s2p_end  = fin;
         s2p_data = fin ? w : 8'h00;
         #1;
         chk("wait_d", s2p_d, 0);
         chk("wait_err", err_timeout, 0);
         chk("wait_valid", out_valid, 0);
         chk("wait_busy", busy, 1);
      end
      if (mode == M_TMO) begin
         exp_err = 1'b1;
      end else begin
         for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            s2p_end   = 1'b0;
            s2p_data  = 8'h00;
            out_ready = (h == hold);
            #1;
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, w);
            chk("out_id", out_id, src);
            chk("out_busy", busy, 1);
            chk("out_gnt", gnt, g);
            chk("out_err", err_timeout, 0);
         end
      end
   endtask

   initial begin
      reset     = 1'b0;
      req       = '0;
      ser_d     = '0;
      s2p_end   = 1'b0;
      s2p_data  = '0;
      out_ready = 1'b1;
      #3;
      chk_zero("rst");
      #4;
      reset = 1'b1;

      // Round robin from reset, out_ready already high at OUT entry.
      for (int s = 0; s < 4; s++)
         frame(4'b1111, 1'b0, s, M_NORM, 0, 1'b0);

      // Single frame, request withdrawn after grant.
      frame(4'b0100, 1'b1, 2, M_NORM, 0, 1'b0);

      // Backpressure with other requests pending.
      frame(4'b0111, 1'b0, 0, M_NORM, 5, 1'b0);

      // Timeout on source 1, then source 0 is served.
      frame(4'b0011, 1'b0, 1, M_TMO, 0, 1'b0);
      frame(4'b0011, 1'b0, 0, M_NORM, 0, 1'b0);

      // End pulse on the final WAIT cycle plus a stray one during SHIFT.
      frame(4'b1000, 1'b1, 3, M_RACE, 0, 1'b1);

      // Reset in the middle of shifting source 1.
      @(negedge clk);
      req = 4'b0010;
      ser_d = '0;
      #1;
      chk("r_idle_err", err_timeout, exp_err);
      exp_err = 1'b0;
      @(negedge clk);
      req = '0;
      #1;
      chk("r_gnt", gnt, 4'b0010);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         ser_d = (k == 4) ? 4'b1111 : 4'b0000;
         #1;
         chk("r_bit", s2p_d, (k == 4));
      end
      #1;
      reset = 1'b0;
      #1;
      chk_zero("mid_rst");
      @(negedge clk);
      reset = 1'b1;
      ser_d = '0;
      frame(4'b1001, 1'b0, 0, M_NORM, 0, 1'b0);

      @(negedge clk);
      req = '0;
      #1;
      chk("end_busy", busy, 0);
      chk("end_gnt", gnt, 0);
      chk("end_valid", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
